// File: rtl/lsq_issue_queue.sv
// In-order load/store issue queue: circular buffer of memory ops, CDB operand
// wakeup, head-only issue (stores also wait for the ROB head).
module lsq_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int ROB_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic                   enq_is_store,
    input  logic [2:0]             enq_funct3,
    input  logic [ROB_IDX_W-1:0]   enq_rob_idx,
    input  logic                   enq_rs1_ready,
    input  logic [ROB_IDX_W-1:0]   enq_rs1_tag,
    input  logic [31:0]            enq_rs1_data,
    input  logic                   enq_rs2_ready,
    input  logic [ROB_IDX_W-1:0]   enq_rs2_tag,
    input  logic [31:0]            enq_rs2_data,
    input  logic [31:0]            enq_imm,
    input  logic                   cdb_valid,
    input  logic [ROB_IDX_W-1:0]   cdb_rob_idx,
    input  logic [31:0]            cdb_data,
    input  logic [ROB_IDX_W-1:0]   rob_head_idx,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic                   issue_is_store,
    output logic [2:0]             issue_funct3,
    output logic [ROB_IDX_W-1:0]   issue_rob_idx,
    output logic [31:0]            issue_addr,
    output logic [31:0]            issue_wdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic                 rdy;
        logic [ROB_IDX_W-1:0] tag;
        logic [31:0]          data;
    } opnd_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_store;
        logic [2:0]           funct3;
        logic [ROB_IDX_W-1:0] rob_idx;
        opnd_t                rs1;
        opnd_t                rs2;
        logic [31:0]          imm;
    } entry_t;

    entry_t           q [DEPTH];
    entry_t           head_ent;
    entry_t           new_ent;
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   cnt;
    logic             enq_fire, deq_fire;

    function automatic opnd_t wake(input opnd_t o);
        opnd_t r;
        r = o;
        if (!o.rdy && cdb_valid && (o.tag == cdb_rob_idx)) begin
            r.rdy  = 1'b1;
            r.data = cdb_data;
        end
        return r;
    endfunction

    // DEPTH is a power of two, so the count MSB is set only when full.
    assign enq_ready = !cnt[PTR_W];
    assign count     = cnt;
    assign head_ent  = q[head];

    assign issue_valid    = head_ent.valid && head_ent.rs1.rdy &&
                            (!head_ent.is_store ||
                             (head_ent.rs2.rdy && (head_ent.rob_idx == rob_head_idx)));
    assign issue_is_store = head_ent.is_store;
    assign issue_funct3   = head_ent.funct3;
    assign issue_rob_idx  = head_ent.rob_idx;
    assign issue_addr     = head_ent.rs1.data + head_ent.imm;
    assign issue_wdata    = head_ent.rs2.data;

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = issue_valid && issue_ready;

    // Incoming operands see this cycle's broadcast so a tag matching the CDB is not lost.
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.is_store = enq_is_store;
        new_ent.funct3   = enq_funct3;
        new_ent.rob_idx  = enq_rob_idx;
        new_ent.rs1      = wake('{rdy: enq_rs1_ready, tag: enq_rs1_tag, data: enq_rs1_data});
        new_ent.rs2      = wake('{rdy: enq_rs2_ready, tag: enq_rs2_tag, data: enq_rs2_data});
        new_ent.imm      = enq_imm;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].valid) begin
                    q[i].rs1 <= wake(q[i].rs1);
                    q[i].rs2 <= wake(q[i].rs2);
                end
            end
            // Head and tail slots differ whenever both fire (never empty and full at once).
            if (deq_fire) begin
                q[head].valid <= 1'b0;
                head          <= head + 1'b1;
            end
            if (enq_fire) begin
                q[tail] <= new_ent;
                tail    <= tail + 1'b1;
            end
            if (enq_fire && !deq_fire)      cnt <= cnt + 1'b1;
            else if (!enq_fire && deq_fire) cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_lsq_issue_queue.sv
// Randomized check of lsq_issue_queue against a queue-based reference model.
module tb_lsq_issue_queue;
    localparam int DEPTH = 8;
    localparam int RW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, enq_valid, enq_ready, enq_is_store;
    logic [2:0]    enq_funct3;
    logic [RW-1:0] enq_rob_idx, enq_rs1_tag, enq_rs2_tag;
    logic          enq_rs1_ready, enq_rs2_ready;
    logic [31:0]   enq_rs1_data, enq_rs2_data, enq_imm;
    logic          cdb_valid;
    logic [RW-1:0] cdb_rob_idx, rob_head_idx;
    logic [31:0]   cdb_data;
    logic          issue_valid, issue_ready, issue_is_store;
    logic [2:0]    issue_funct3;
    logic [RW-1:0] issue_rob_idx;
    logic [31:0]   issue_addr, issue_wdata;
    logic [$clog2(DEPTH):0] count;

    lsq_issue_queue #(.DEPTH(DEPTH), .ROB_IDX_W(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_is_store(enq_is_store),
        .enq_funct3(enq_funct3), .enq_rob_idx(enq_rob_idx),
        .enq_rs1_ready(enq_rs1_ready), .enq_rs1_tag(enq_rs1_tag), .enq_rs1_data(enq_rs1_data),
        .enq_rs2_ready(enq_rs2_ready), .enq_rs2_tag(enq_rs2_tag), .enq_rs2_data(enq_rs2_data),
        .enq_imm(enq_imm), .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
        .rob_head_idx(rob_head_idx), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_is_store(issue_is_store), .issue_funct3(issue_funct3),
        .issue_rob_idx(issue_rob_idx), .issue_addr(issue_addr), .issue_wdata(issue_wdata),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        bit [2:0]    f3;
        bit [RW-1:0] rob;
        bit          r1;
        bit [RW-1:0] t1;
        bit [31:0]   d1;
        bit          r2;
        bit [RW-1:0] t2;
        bit [31:0]   d2;
        bit [31:0]   imm;
    } me_t;

    me_t mq[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void wk(inout bit r, input bit [RW-1:0] t, inout bit [31:0] d);
        if (!r && cdb_valid && t == cdb_rob_idx) begin
            r = 1'b1;
            d = cdb_data;
        end
    endfunction

    // Called just after a negedge with inputs applied: check, advance model, move to next negedge.
    task automatic cycle();
        bit  ev, deq, enq;
        me_t h, n;
        #1;
        ev = 1'b0;
        chk("enq_ready", {31'b0, enq_ready}, {31'b0, mq.size() < DEPTH});
        chk("count", 32'(count), 32'(mq.size()));
        if (mq.size() > 0) begin
            h  = mq[0];
            ev = h.r1 && (!h.st || (h.r2 && h.rob == rob_head_idx));
            chk("is_store", {31'b0, issue_is_store}, {31'b0, h.st});
            chk("funct3", 32'(issue_funct3), 32'(h.f3));
            chk("rob_idx", 32'(issue_rob_idx), 32'(h.rob));
            chk("addr", issue_addr, h.d1 + h.imm);
            chk("wdata", issue_wdata, h.d2);
        end
        chk("issue_valid", {31'b0, issue_valid}, {31'b0, ev});
        if (flush) mq.delete();
        else begin
            deq = ev && issue_ready;
            enq = enq_valid && (mq.size() < DEPTH);
            foreach (mq[i]) begin
                wk(mq[i].r1, mq[i].t1, mq[i].d1);
                wk(mq[i].r2, mq[i].t2, mq[i].d2);
            end
            if (deq) void'(mq.pop_front());
            if (enq) begin
                n = '{enq_is_store, enq_funct3, enq_rob_idx, enq_rs1_ready, enq_rs1_tag,
                      enq_rs1_data, enq_rs2_ready, enq_rs2_tag, enq_rs2_data, enq_imm};
                wk(n.r1, n.t1, n.d1);
                wk(n.r2, n.t2, n.d2);
                mq.push_back(n);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_enq(input bit v, input bit st, input bit [RW-1:0] rob,
                           input bit r1, input bit [RW-1:0] t1, input bit [31:0] d1,
                           input bit r2, input bit [RW-1:0] t2, input bit [31:0] d2,
                           input bit [31:0] imm);
        enq_valid = v; enq_is_store = st; enq_funct3 = 3'b010; enq_rob_idx = rob;
        enq_rs1_ready = r1; enq_rs1_tag = t1; enq_rs1_data = d1;
        enq_rs2_ready = r2; enq_rs2_tag = t2; enq_rs2_data = d2; enq_imm = imm;
    endtask

    task automatic rand_in();
        flush        = ($urandom_range(0, 39) == 0);
        enq_valid    = $urandom_range(0, 2) != 0;
        enq_is_store = $urandom_range(0, 1);
        enq_funct3   = 3'($urandom);
        enq_rob_idx  = RW'($urandom);
        enq_rs1_ready = $urandom_range(0, 1);
        enq_rs1_tag  = RW'($urandom);
        enq_rs1_data = $urandom;
        enq_rs2_ready = $urandom_range(0, 1);
        enq_rs2_tag  = RW'($urandom);
        enq_rs2_data = $urandom;
        enq_imm      = $urandom;
        cdb_valid    = $urandom_range(0, 1);
        cdb_rob_idx  = RW'($urandom);
        cdb_data     = $urandom;
        issue_ready  = $urandom_range(0, 3) != 0;
        if (mq.size() > 0 && $urandom_range(0, 1)) rob_head_idx = mq[0].rob;
        else rob_head_idx = RW'($urandom);
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_enq_ready", {31'b0, enq_ready}, 32'd1);
        chk("arst_issue_valid", {31'b0, issue_valid}, 32'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        cdb_valid = 1'b0; cdb_rob_idx = '0; cdb_data = '0; rob_head_idx = '0;
        set_enq(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_enq_ready", {31'b0, enq_ready}, 32'd1);
        chk("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
        chk("rst_addr", issue_addr, 32'd0);
        chk("rst_wdata", issue_wdata, 32'd0);
        chk("rst_rob", 32'(issue_rob_idx), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // load, ready operand: issues the cycle after enqueue
        issue_ready = 1'b1;
        set_enq(1, 0, 3, 1, 0, 32'h1000, 1, 0, 0, 32'h4); cycle();
        enq_valid = 1'b0; cycle();
        chk("dir_load_count", 32'(count), 32'd0);

        // store waits for rs2 wakeup and ROB head
        rob_head_idx = 2;
        set_enq(1, 1, 6, 1, 0, 32'h2000, 0, 5, 0, 0); cycle();
        enq_valid = 1'b0; cdb_valid = 1'b1; cdb_rob_idx = 5; cdb_data = 32'hDEADBEEF; cycle();
        cdb_valid = 1'b0; cycle();
        rob_head_idx = 6; cycle();
        cycle();

        // enqueue-time CDB bypass
        set_enq(1, 0, 1, 0, 7, 0, 1, 0, 0, 32'h10);
        cdb_valid = 1'b1; cdb_rob_idx = 7; cdb_data = 32'h80; cycle();
        enq_valid = 1'b0; cdb_valid = 1'b0; cycle();

        // fill, stall, then drain with concurrent enqueue across the wrap
        issue_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_enq(1, 0, RW'(i), 1, 0, 32'h100 * i, 1, 0, i, 0); cycle();
        end
        issue_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_enq(1, 0, RW'(i), 1, 0, 32'h40 * i, 1, 0, i, 4); cycle();
        end
        enq_valid = 1'b0;
        repeat (10) cycle();

        // stalled head blocks a ready younger entry; then wake head
        set_enq(1, 0, 2, 0, 9, 0, 1, 0, 0, 0); cycle();
        set_enq(1, 0, 3, 1, 0, 32'h55, 1, 0, 0, 0); cycle();
        enq_valid = 1'b0; cycle();
        cdb_valid = 1'b1; cdb_rob_idx = 9; cdb_data = 32'h700; cycle();
        cdb_valid = 1'b0; repeat (3) cycle();

        // flush with enqueue, then async reset mid-cycle
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_enq(1, 0, RW'(i), 1, 0, i, 1, 0, 0, 0); cycle();
        end
        flush = 1'b1; cycle();
        flush = 1'b0; enq_valid = 1'b0; cycle();
        set_enq(1, 0, 4, 1, 0, 32'h9, 1, 0, 0, 0); cycle();
        cycle();
        async_reset();

        for (int i = 0; i < 3000; i++) begin
            rand_in();
            cycle();
            if (i == 1500) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsq_issue_queue.md
Name: lsq_issue_queue

Overview:
- In-order load/store queue directly upstream of the memory unit.
- Accepts memory micro-ops from dispatch and wakes their operands by snooping the common data bus (CDB).
- Issues the head entry to the memory unit once its operands are ready. Stores additionally wait until they reach the ROB head.
- Strict in-order issue, so there is no store-to-load forwarding and no memory disambiguation.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of two, at least 2.
- ROB_IDX_W, 4, width of ROB index / operand tag.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries.
- enq_valid  in  1  dispatch presents a memory op.
- enq_ready  out  1  queue can accept (not full).
- enq_is_store  in  1  1 = store, 0 = load.
- enq_funct3  in  3  RV32I width/sign field.
- enq_rob_idx  in  ROB_IDX_W  ROB slot of this op.
- enq_rs1_ready  in  1  rs1 value already valid.
- enq_rs1_tag  in  ROB_IDX_W  producer ROB index of rs1 when not ready.
- enq_rs1_data  in  32  rs1 value when ready.
- enq_rs2_ready  in  1  as for rs1; ignored for loads.
- enq_rs2_tag  in  ROB_IDX_W  as for rs1.
- enq_rs2_data  in  32  as for rs1.
- enq_imm  in  32  sign-extended offset.
- cdb_valid  in  1  result broadcast valid.
- cdb_rob_idx  in  ROB_IDX_W  broadcast producer tag.
- cdb_data  in  32  broadcast value.
- rob_head_idx  in  ROB_IDX_W  ROB index of the oldest uncommitted instruction.
- issue_valid  out  1  head entry issuable.
- issue_ready  in  1  memory unit accepts (driven as not mem_stall).
- issue_is_store  out  1  head op type.
- issue_funct3  out  3  head funct3.
- issue_rob_idx  out  ROB_IDX_W  head ROB index.
- issue_addr  out  32  rs1 + imm, unaligned byte address.
- issue_wdata  out  32  rs2 value, unshifted.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage is a circular buffer with head/tail pointers of $clog2(DEPTH) bits (natural wrap) plus a count register.
- Each entry holds: valid, is_store, funct3, rob_idx, rs1 {rdy, tag, data}, rs2 {rdy, tag, data}, imm.
- Reset (rst low, asynchronous): pointers, count and all entry valid/rdy bits clear to 0; entry payloads clear to 0. Consequently every output is 0 except enq_ready, which is 1.
- enq_ready = (count < DEPTH). It does not depend on a same-cycle dequeue, so a full queue refuses enqueue even while issuing.
- Enqueue fires on enq_valid && enq_ready at the clock edge: the entry is written at tail, tail increments, count increments.
- Same-cycle CDB bypass on enqueue: if an enqueued operand is not ready, cdb_valid is high and cdb_rob_idx equals its tag, the entry stores rdy=1 with data=cdb_data.
- Wakeup: every cycle, each valid entry whose rs1 (or rs2) is not ready and whose tag matches cdb_rob_idx while cdb_valid is high sets rdy=1 and data=cdb_data at the edge. rs1 and rs2 may both wake in the same cycle.
- Issue condition is combinational from the head entry only:
  - issue_valid = head.valid && head.rs1.rdy && (!head.is_store || (head.rs2.rdy && head.rob_idx == rob_head_idx)).
  - issue_addr = head.rs1.data + head.imm, modulo 2^32.
  - issue_wdata = head.rs2.data.
  - Payload outputs are driven from the head entry regardless of issue_valid; they read 0 when the queue is empty after reset.
- Dequeue fires on issue_valid && issue_ready: head.valid clears, head increments, count decrements.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- A head op whose operand is woken this cycle is not issued until the next cycle (no CDB-to-issue bypass).
- Younger ready entries never bypass a stalled head.
- flush (synchronous, at the edge): all entries invalidated, head = tail = 0, count = 0.
  - Flush overrides an enqueue or dequeue in the same cycle.
  - issue_valid may be high during the flush cycle; the memory unit is expected to ignore issues during flush.
- Reset asserted mid-operation: the queue empties immediately and asynchronously; no partial state survives.

Test Plan:
- Reset, then enqueue load (rs1 ready=0x1000, imm=0x4, rob 3) with issue_ready=1 → issue_valid=1 next cycle, issue_addr=0x1004, count goes 1→0 after the edge.
- Enqueue store (rs1 ready=0x2000, rs2 tag 5 not ready, rob 6) with rob_head_idx=2 → issue_valid=0. CDB broadcasts tag 5, data 0xDEADBEEF → still 0. rob_head_idx set to 6 → issue_valid=1, issue_wdata=0xDEADBEEF.
- Enqueue load with rs1 tag 7 while the CDB broadcasts tag 7, data 0x80 in the same cycle → entry captured ready; issues next cycle with addr=0x80+imm.
- Fill 8 entries → enq_ready=0, count=8. Hold issue_ready=0 → no dequeue. Then issue_ready=1 with simultaneous enq_valid → one dequeue, no enqueue that cycle. Continue past wrap: head/tail 7→0, FIFO order preserved.
- Head load not ready while the entry behind it is ready → issue_valid=0 and no reordering. Wake the head → both issue in order on consecutive cycles.
- With 3 entries, assert flush together with enq_valid → count=0, issue_valid=0 next cycle. Assert rst low mid-cycle → count=0 and enq_ready=1 immediately, without waiting for a clock edge.
